tdm_chan_router: RTL

Parametrised successor to the fixed two-way 256-bit TDM pass-thru mux. Routes any output channel from any of NSRC parallel TDM frame sources (tdm2p outputs, register-injected frames, DSP returns) into one output frame for gainBal/p2tdm. Holds per-source frames and applies routing config glitch-free at frame boundaries. Provides per-source stale detection and a repeated-frame counter.

---
 rtl/tdm_chan_router.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/tdm_chan_router.sv
// TDM channel router: holds the latest frame from each source and builds one output frame
// per master strobe, with boundary-aligned config swaps, stale tracking and a repeat counter.
module tdm_chan_router #(
   parameter int NSRC    = 4,
   parameter int NCH     = 8,
   parameter int CW      = 32,
   parameter int TIMEOUT = 4096,
   parameter int SW      = (NSRC > 1) ? $clog2(NSRC) : 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    enable,
   input  logic [NSRC-1:0]         src_valid,
   input  logic [NSRC*NCH*CW-1:0]  src_pdata,
   input  logic [NCH*SW-1:0]       cfg_route,
   input  logic [NCH-1:0]          cfg_mute,
   input  logic [SW-1:0]           cfg_master,
   input  logic                    cfg_load,
   input  logic                    cnt_clr,
   output logic                    out_valid,
   output logic [NCH*CW-1:0]       out_pdata,
   output logic [NSRC-1:0]         src_stale,
   output logic [15:0]             repeat_cnt,
   output logic                    cfg_pending
);

   localparam int FW = NCH * CW;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

   logic [FW-1:0]     hold_q   [NSRC];
   logic [FW-1:0]     curFrame [NSRC];
   logic [TW-1:0]     timer_q  [NSRC];
   logic [TW-1:0]     timer_d  [NSRC];
   logic [NSRC-1:0]   stale, effStale;
   logic [NSRC-1:0]   fresh_q, fresh_d;
   logic [NCH*SW-1:0] actRoute_q, actRoute_d, pendRoute_q, pendRoute_d;
   logic [NCH-1:0]    actMute_q, actMute_d, pendMute_q, pendMute_d;
   logic [SW-1:0]     actMaster_q, actMaster_d, pendMaster_q, pendMaster_d;
   logic              pending_q, pending_d;
   logic              outValid_q, outValid_d;
   logic [FW-1:0]     outData_q, outData_d;
   logic [15:0]       rptCnt_q, rptCnt_d;
   logic              masterInRange, masterValid, masterStale;
   logic              emit, swapCfg, repeatHit;
   logic [FW-1:0]     routedFrame;

   // Same-cycle source data bypasses the holding register; a source strobing now is never stale.
   always_comb begin : frame_view
      for (int s = 0; s < NSRC; s++) begin
         curFrame[s] = src_valid[s] ? src_pdata[s*FW +: FW] : hold_q[s];
         stale[s]    = (timer_q[s] == TMAX);
         effStale[s] = stale[s] & ~src_valid[s];
      end
   end

   always_comb begin : master_decode
      masterInRange = (int'(actMaster_q) < NSRC);
      masterValid   = 1'b0;
      masterStale   = 1'b1;
      if (masterInRange) begin
         masterValid = src_valid[actMaster_q];
         masterStale = stale[actMaster_q];
      end
      emit    = masterValid & enable;
      // An absent or stale master would otherwise strand a pending config forever.
      swapCfg = pending_q & ~cfg_load & (masterValid | masterStale);
   end

   always_comb begin : route_select
      logic [SW-1:0] sel;
      logic          chanOk;
      sel         = '0;
      chanOk      = 1'b0;
      routedFrame = '0;
      repeatHit   = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         sel    = actRoute_q[c*SW +: SW];
         chanOk = !actMute_q[c] && (int'(sel) < NSRC) && !effStale[sel];
         if (chanOk) begin
            routedFrame[c*CW +: CW] = curFrame[sel][c*CW +: CW];
            if (!fresh_q[sel] && !src_valid[sel]) begin
               repeatHit = 1'b1;
            end
         end
      end
   end

   always_comb begin : next_state
      for (int s = 0; s < NSRC; s++) begin
         if (src_valid[s]) begin
            timer_d[s] = '0;
         end else if (timer_q[s] == TMAX) begin
            timer_d[s] = TMAX;
         end else begin
            timer_d[s] = timer_q[s] + TW'(1);
         end
      end

      fresh_d      = masterValid ? '0 : (fresh_q | src_valid);

      pendRoute_d  = cfg_load ? cfg_route  : pendRoute_q;
      pendMute_d   = cfg_load ? cfg_mute   : pendMute_q;
      pendMaster_d = cfg_load ? cfg_master : pendMaster_q;
      pending_d    = cfg_load | (pending_q & ~swapCfg);

      actRoute_d   = swapCfg ? pendRoute_q  : actRoute_q;
      actMute_d    = swapCfg ? pendMute_q   : actMute_q;
      actMaster_d  = swapCfg ? pendMaster_q : actMaster_q;

      outValid_d   = emit;
      outData_d    = emit ? routedFrame : outData_q;

      rptCnt_d     = rptCnt_q;
      if (cnt_clr) begin
         rptCnt_d = '0;
      end else if (emit && repeatHit && (rptCnt_q != 16'hFFFF)) begin
         rptCnt_d = rptCnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int s = 0; s < NSRC; s++) begin
            hold_q[s]  <= '0;
            timer_q[s] <= TMAX;
         end
         fresh_q      <= '0;
         actRoute_q   <= '0;
         actMute_q    <= '0;
         actMaster_q  <= '0;
         pendRoute_q  <= '0;
         pendMute_q   <= '0;
         pendMaster_q <= '0;
         pending_q    <= 1'b0;
         outValid_q   <= 1'b0;
         outData_q    <= '0;
         rptCnt_q     <= '0;
      end else begin
         for (int s = 0; s < NSRC; s++) begin
            hold_q[s]  <= curFrame[s];
            timer_q[s] <= timer_d[s];
         end
         fresh_q      <= fresh_d;
         actRoute_q   <= actRoute_d;
         actMute_q    <= actMute_d;
         actMaster_q  <= actMaster_d;
         pendRoute_q  <= pendRoute_d;
         pendMute_q   <= pendMute_d;
         pendMaster_q <= pendMaster_d;
         pending_q    <= pending_d;
         outValid_q   <= outValid_d;
         outData_q    <= outData_d;
         rptCnt_q     <= rptCnt_d;
      end
   end

   assign out_valid   = outValid_q;
   assign out_pdata   = outData_q;
   assign src_stale   = stale;
   assign repeat_cnt  = rptCnt_q;
   assign cfg_pending = pending_q;

endmodule
